draw_scheduler: RTL and testbench
=================================

Name: draw_scheduler

Overview:
- Sequences the shared framebuffer write bus between up to NUM_SOURCES draw sources, such as the sensor-calibration overlay and the sprite and text layers.
- On each display frame_start it grants enabled sources one at a time, in ascending index order.
- For each grant it drives write_source_sel, pulses write_awaited, then tracks the source's write_active until the source finishes.
- Emits frame completion, error status and the optional buffer swap.

Parameters:
NUM_SOURCES, 4, number of draw sources on the shared bus (1..16)
SEL_WIDTH, 2, width of write_source_sel; must satisfy 2**SEL_WIDTH >= NUM_SOURCES
START_TIMEOUT, 16, max cycles allowed from grant to write_active rising before the source is skipped
CNT_WIDTH, 8, width of the start-timeout counter; must satisfy 2**CNT_WIDTH > START_TIMEOUT

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse from the display timing block (vsync)
src_enable  in  NUM_SOURCES  bit i=1: source i draws this frame; sampled only on an accepted frame_start
write_active  in  1  shared bus busy flag, driven by the selected source
write_source_sel  out  SEL_WIDTH  index of the granted source; held stable from grant until completion
write_awaited  out  1  one-cycle grant pulse to the selected source
busy  out  1  high while a frame sequence is in progress (state != IDLE)
frame_done  out  1  one-cycle pulse when all enabled sources have completed or been skipped
timeout_err  out  NUM_SOURCES  sticky; bit i set when source i missed START_TIMEOUT
frame_overrun  out  1  sticky; set when frame_start arrives while busy
buffer_sel  out  1  front/back buffer select (see Optional Feature)

Behaviour:
- All outputs are registered. Reset is synchronous and active-high.
- Reset values: every output 0, state IDLE, mask 0, pending 0, counter 0.
- Asserting reset mid-operation abandons the frame immediately. The sources have their own reset.
- States: IDLE, FIND, GRANT, WAIT_START, WAIT_END, DONE.
- IDLE: on frame_start, mask <= src_enable and the next state is FIND.
- FIND:
  - If mask == 0, the next state is DONE.
  - Otherwise write_source_sel <= lowest set index, that mask bit is cleared, and the next state is GRANT.
- GRANT:
  - write_awaited = 1 for exactly this one cycle; the counter is cleared.
  - The next state is WAIT_START.
- WAIT_START:
  - write_active == 1: next state WAIT_END.
  - Otherwise the counter increments. When the counter reaches START_TIMEOUT-1, set timeout_err[sel] and go to FIND.
  - A compliant source raises write_active 2 cycles after the GRANT cycle.
- WAIT_END: write_active == 0 leads to FIND. There is no upper bound on draw length.
- DONE:
  - frame_done = 1 for one cycle.
  - If pending == 1: clear pending, mask <= src_enable, go to FIND.
  - Otherwise go to IDLE.
- Latency: with src_enable == 0, frame_done rises 3 cycles after the frame_start cycle (IDLE -> FIND -> DONE, output registered).
- frame_start while busy:
  - Set frame_overrun and pending. Multiple overruns collapse into a single pending frame.
  - A frame_start in the same cycle as DONE also counts as pending.
- write_source_sel holds its last value while in IDLE. It never changes in GRANT, WAIT_START or WAIT_END.
- write_active is sampled only in WAIT_START and WAIT_END. Outside those states it may be undriven (Z/X) and must be ignored.
- An index >= NUM_SOURCES is never granted. src_enable has exactly NUM_SOURCES bits.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: DRAW_SCHED_DOUBLE_BUFFER_EN.
- Defined: buffer_sel toggles on the cycle frame_done is asserted. Draw sources write the back buffer and the display reads the front buffer.
- Not defined: buffer_sel is constant 0, with no toggle logic (single buffer).

Decomposition:
- Package draw_sched_pkg holds:
  - the state enum type draw_sched_state_t (the six states above);
  - localparam DRAW_SCHED_MAX_SOURCES = 16;
  - the source-index typedef.
- Sub-module draw_sched_prio_enc: combinational lowest-set-bit encoder.
  - Input: NUM_SOURCES-bit mask.
  - Outputs: SEL_WIDTH index and 1-bit valid.
  - Used in FIND.

Test Plan:
1. src_enable=4'b0101; source models raise write_active 2 cycles after grant and hold it 20 cycles.
   - Required: grant to sel=0, then sel=2.
   - Required: write_awaited pulses exactly twice, 1 cycle each.
   - Required: frame_done once; timeout_err=0.
2. src_enable=4'b0010; source 1 never responds.
   - Required: write_awaited pulse at sel=1.
   - Required: after 16 cycles timeout_err=4'b0010, then frame_done; busy falls the cycle after.
3. src_enable=0 with a frame_start pulse.
   - Required: frame_done 3 cycles later; write_awaited never asserted.
4. A second frame_start during source 0's 500-cycle draw.
   - Required: frame_overrun=1.
   - Required: after frame_done, a new sequence starts from FIND with no return to IDLE; a total of 2 frame_done pulses.
5. Assert reset for 1 cycle while in WAIT_END.
   - Required: next cycle all outputs 0 and state IDLE; a subsequent frame_start runs normally.
6. With DRAW_SCHED_DOUBLE_BUFFER_EN defined, run 3 frames.
   - Required: buffer_sel sequence 0->1->0->1, toggling on each frame_done cycle.
   - Required: without the macro, buffer_sel stays 0.

Source files
------------

// File: rtl/draw_sched_pkg.sv
// Shared types for the framebuffer draw scheduler: FSM state encoding and source index.
package draw_sched_pkg;

  localparam int DRAW_SCHED_MAX_SOURCES = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIND,
    S_GRANT,
    S_WAIT_START,
    S_WAIT_END,
    S_DONE
  } draw_sched_state_t;

  typedef logic [$clog2(DRAW_SCHED_MAX_SOURCES)-1:0] draw_sched_src_idx_t;

endpackage

// File: rtl/draw_sched_prio_enc.sv
// Combinational lowest-set-bit encoder; picks the next source to grant from the pending mask.
module draw_sched_prio_enc
  import draw_sched_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  parameter int SEL_WIDTH   = 2
) (
  input  logic [NUM_SOURCES-1:0] mask,
  output logic [SEL_WIDTH-1:0]   idx,
  output logic                   valid
);

  draw_sched_src_idx_t first;

  // Scan from the top so the last hit (the lowest index) wins.
  always_comb begin
    first = '0;
    valid = 1'b0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first = draw_sched_src_idx_t'(i);
        valid = 1'b1;
      end
    end
    idx = SEL_WIDTH'(first);
  end

endmodule

// File: rtl/draw_scheduler.sv
// Grants the shared framebuffer write bus to enabled draw sources in index order, once per frame.
// Define DRAW_SCHED_DOUBLE_BUFFER_EN to toggle buffer_sel on every frame_done.
module draw_scheduler
  import draw_sched_pkg::*;
#(
  parameter int NUM_SOURCES   = 4,
  parameter int SEL_WIDTH     = 2,
  parameter int START_TIMEOUT = 16,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic [NUM_SOURCES-1:0] src_enable,
  input  logic                   write_active,
  output logic [SEL_WIDTH-1:0]   write_source_sel,
  output logic                   write_awaited,
  output logic                   busy,
  output logic                   frame_done,
  output logic [NUM_SOURCES-1:0] timeout_err,
  output logic                   frame_overrun,
  output logic                   buffer_sel
);

  draw_sched_state_t      state_q, state_d;
  logic [NUM_SOURCES-1:0] mask_q, mask_d;
  logic                   pending_q, pending_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic                   awaited_q, awaited_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic [NUM_SOURCES-1:0] err_q, err_d;
  logic                   ovr_q, ovr_d;

  logic [SEL_WIDTH-1:0]   enc_idx;
  logic                   enc_valid;

  draw_sched_prio_enc #(
    .NUM_SOURCES (NUM_SOURCES),
    .SEL_WIDTH   (SEL_WIDTH)
  ) u_prio_enc (
    .mask  (mask_q),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    err_d     = err_q;
    ovr_d     = ovr_q;
    awaited_d = (state_q == S_GRANT);
    done_d    = (state_q == S_DONE);
    busy_d    = (state_q != S_IDLE);

    // Overruns collapse into one pending frame; DONE consumes it below.
    if (frame_start && state_q != S_IDLE) begin
      ovr_d     = 1'b1;
      pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          mask_d  = src_enable;
          state_d = S_FIND;
        end
      end
      S_FIND: begin
        if (!enc_valid) begin
          state_d = S_DONE;
        end else begin
          sel_d   = enc_idx;
          mask_d  = mask_q & (mask_q - NUM_SOURCES'(1));
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        cnt_d   = '0;
        state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (write_active) begin
          state_d = S_WAIT_END;
        end else if (cnt_q == CNT_WIDTH'(START_TIMEOUT - 1)) begin
          err_d   = err_q | (NUM_SOURCES'(1) << sel_q);
          state_d = S_FIND;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      S_WAIT_END: begin
        if (!write_active) state_d = S_FIND;
      end
      S_DONE: begin
        if (pending_q || frame_start) begin
          pending_d = 1'b0;
          mask_d    = src_enable;
          state_d   = S_FIND;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      sel_q     <= '0;
      awaited_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      awaited_q <= awaited_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
    end
  end

`ifdef DRAW_SCHED_DOUBLE_BUFFER_EN
  logic buf_q, buf_d;

  // Flips on the same edge that raises frame_done.
  always_comb buf_d = buf_q ^ (state_q == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) buf_q <= 1'b0;
    else       buf_q <= buf_d;
  end

  assign buffer_sel = buf_q;
`else
  assign buffer_sel = 1'b0;
`endif

  assign write_source_sel = sel_q;
  assign write_awaited    = awaited_q;
  assign busy             = busy_q;
  assign frame_done       = done_q;
  assign timeout_err      = err_q;
  assign frame_overrun    = ovr_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: timeline model of grants/timeouts/frame_done plus directed and random frames.
module tb_draw_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic [3:0] src_enable = '0;
  logic       write_active = 1'b0;
  logic [1:0] write_source_sel;
  logic       write_awaited, busy, frame_done, frame_overrun, buffer_sel;
  logic [3:0] timeout_err;

  draw_scheduler #(
    .NUM_SOURCES(4), .SEL_WIDTH(2), .START_TIMEOUT(16), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .src_enable(src_enable),
    .write_active(write_active), .write_source_sel(write_source_sel),
    .write_awaited(write_awaited), .busy(busy), .frame_done(frame_done),
    .timeout_err(timeout_err), .frame_overrun(frame_overrun), .buffer_sel(buffer_sel)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-source behaviour: responds 2 cycles after grant and draws len cycles, or never responds.
  bit resp[4];
  int len[4];

  // Expected timeline, keyed by cycle number.
  bit         exp_aw[int];
  int         exp_sel[int];
  bit         exp_dn[int];
  logic [3:0] err_at[int];
  logic [3:0] exp_err = '0;
  logic       exp_buf = 1'b0;
  bit         chk_en = 1'b0;
  int         aw_cnt = 0;
  int         dn_cnt = 0;
  int         grant_q[$];
  int         src_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Each source slot: FIND f, GRANT f+1, grant pulse visible f+2.
  // Responder: active f+3 .. f+2+len, next FIND at f+4+len.
  // Silent: 16 waiting cycles, error visible and next FIND at f+18.
  // Empty mask: DONE at f+1, frame_done visible at f+2.
  task automatic plan(input int f0, input logic [3:0] en, output int d);
    int f;
    f = f0;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) begin
        exp_aw[f + 2]  = 1'b1;
        exp_sel[f + 2] = i;
        if (resp[i]) begin
          f = f + 4 + len[i];
        end else begin
          err_at[f + 18] = 4'(1 << i);
          f = f + 18;
        end
      end
    end
    exp_dn[f + 2] = 1'b1;
    d = f + 1;
  endtask

  task automatic run_frame(input logic [3:0] en, output int c0, output int d);
    src_enable  = en;
    frame_start = 1'b1;
    c0 = cyc;
    plan(c0 + 1, en, d);
    step();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    step(3);
    while (busy && n < budget) begin
      step();
      n++;
    end
    chk("idle_reached", busy, 0);
    step(2);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sel"}, write_source_sel, 0);
    chk({tag, "_awaited"}, write_awaited, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_err"}, timeout_err, 0);
    chk({tag, "_overrun"}, frame_overrun, 0);
    chk({tag, "_buf"}, buffer_sel, 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      if (err_at.exists(cyc)) exp_err = exp_err | err_at[cyc];
      chk("awaited", write_awaited, exp_aw.exists(cyc));
      if (write_awaited) begin
        aw_cnt++;
        grant_q.push_back(int'(write_source_sel));
        if (exp_sel.exists(cyc)) chk("sel", write_source_sel, exp_sel[cyc]);
      end
      chk("frame_done", frame_done, exp_dn.exists(cyc));
      if (frame_done) dn_cnt++;
`ifdef DRAW_SCHED_DOUBLE_BUFFER_EN
      if (exp_dn.exists(cyc)) exp_buf = ~exp_buf;
`endif
      chk("timeout_err", timeout_err, exp_err);
      chk("buffer_sel", buffer_sel, exp_buf);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (write_awaited) begin
        src_s = int'(write_source_sel);
        if (resp[src_s]) begin
          @(posedge clk);
          #1 write_active = 1'b1;
          repeat (len[src_s]) @(posedge clk);
          #1 write_active = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, d, d2, aw0, dn0, n;
    logic b1, b2, b3;

    for (int i = 0; i < 4; i++) begin
      resp[i] = 1'b1;
      len[i]  = 20;
    end
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    chk_all_zero("reset");
    chk_en = 1'b1;
    step(2);

    // Two compliant sources, 20-cycle draws.
    aw0 = aw_cnt; dn0 = dn_cnt;
    grant_q.delete();
    run_frame(4'b0101, c0, d);
    wait_idle(300);
    chk("t1_grants", aw_cnt - aw0, 2);
    chk("t1_grant_list_len", grant_q.size(), 2);
    if (grant_q.size() == 2) begin
      chk("t1_first_sel", grant_q[0], 0);
      chk("t1_second_sel", grant_q[1], 2);
    end
    chk("t1_dones", dn_cnt - dn0, 1);
    chk("t1_err", timeout_err, 4'b0000);

    // Silent source 1: skipped after 16 waiting cycles.
    resp[1] = 1'b0;
    run_frame(4'b0010, c0, d);
    n = 0;
    while (!frame_done && n < 100) begin
      step();
      n++;
    end
    chk("t2_done_seen", frame_done, 1);
    chk("t2_done_cycle", cyc, c0 + 21);
    chk("t2_err", timeout_err, 4'b0010);
    chk("t2_busy_at_done", busy, 1);
    step();
    chk("t2_busy_after", busy, 0);
    step(2);
    resp[1] = 1'b1;

    // Empty frame: frame_done 3 cycles after frame_start, no grant.
    aw0 = aw_cnt;
    run_frame(4'b0000, c0, d);
    step();
    chk("t3_no_done_yet", frame_done, 0);
    step();
    chk("t3_done_latency", frame_done, 1);
    wait_idle(20);
    chk("t3_no_grant", aw_cnt - aw0, 0);

    // Overrun during a 500-cycle draw: one pending frame follows without idling.
    len[0] = 500;
    dn0 = dn_cnt;
    run_frame(4'b0001, c0, d);
    plan(d + 1, 4'b0001, d2);
    step(50);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("t4_overrun", frame_overrun, 1);
    step(20);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    if (cyc < d + 2) step(d + 2 - cyc);
    chk("t4_busy_no_idle", busy, 1);
    wait_idle(1200);
    chk("t4_dones", dn_cnt - dn0, 2);
    chk("t4_overrun_sticky", frame_overrun, 1);

    // Reset while a source is drawing.
    len[0] = 30;
    run_frame(4'b0001, c0, d);
    n = 0;
    while (!write_active && n < 20) begin
      step();
      n++;
    end
    chk("t5_drawing", write_active, 1);
    step(5);
    chk_en = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_all_zero("t5_after_reset");
    exp_aw.delete(); exp_sel.delete(); exp_dn.delete(); err_at.delete();
    exp_err = '0;
    exp_buf = 1'b0;
    step();
    chk("t5_idle", busy, 0);
    step(40);
    chk_en = 1'b1;
    dn0 = dn_cnt;
    len[0] = 6;
    run_frame(4'b0001, c0, d);
    wait_idle(100);
    chk("t5_recover_done", dn_cnt - dn0, 1);

    // buffer_sel across three frames (starts at 1 after the recovery frame when double-buffered).
    run_frame(4'b0000, c0, d); wait_idle(20); b1 = buffer_sel;
    run_frame(4'b0000, c0, d); wait_idle(20); b2 = buffer_sel;
    run_frame(4'b0000, c0, d); wait_idle(20); b3 = buffer_sel;
`ifdef DRAW_SCHED_DOUBLE_BUFFER_EN
    chk("t6_buf1", b1, 0);
    chk("t6_buf2", b2, 1);
    chk("t6_buf3", b3, 0);
`else
    chk("t6_buf1", b1, 0);
    chk("t6_buf2", b2, 0);
    chk("t6_buf3", b3, 0);
`endif

    // Random frames.
    for (int k = 0; k < 14; k++) begin
      for (int i = 0; i < 4; i++) begin
        resp[i] = ($urandom_range(0, 3) != 0);
        len[i]  = $urandom_range(1, 12);
      end
      run_frame(4'($urandom_range(0, 15)), c0, d);
      wait_idle(400);
    end
    chk("final_no_overrun", frame_overrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
